// File: rtl/roach_rst_pkg.sv
// Shared definitions for the reset sequencer: state encoding, default timing
// constants and small elaboration-time helpers used to size counters.
package roach_rst_pkg;

    localparam int DEF_LOCK_CYCLES     = 1024;
    localparam int DEF_IDLY_RST_CYCLES = 16;
    localparam int DEF_USER_RST_CYCLES = 64;
    localparam int DEF_TIMEOUT_CYCLES  = 4096;
    localparam int DEF_MAX_RETRIES     = 3;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_LOCK_QUAL = 3'd1,
        ST_IDLY_RST  = 3'd2,
        ST_IDLY_WAIT = 3'd3,
        ST_USER_RST  = 3'd4,
        ST_RUN       = 3'd5,
        ST_ERROR     = 3'd6
    } rst_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold any value in 0..n.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Two-flop synchronizer bringing one asynchronous level into the dly_clk domain.
module rst_seq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/roach_reset_sequencer.sv
// Power-up reset sequencer: qualifies clock lock, pulses IDELAYCTRL reset, waits
// for ready, then releases the user reset. Define RST_SEQ_TIMEOUT_EN to enable
// the IDELAY ready timeout / retry / ERROR path.
module roach_reset_sequencer
    import roach_rst_pkg::*;
#(
    parameter int LOCK_CYCLES     = DEF_LOCK_CYCLES,
    parameter int IDLY_RST_CYCLES = DEF_IDLY_RST_CYCLES,
    parameter int USER_RST_CYCLES = DEF_USER_RST_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES     = DEF_MAX_RETRIES
) (
    input  logic       dly_clk,
    input  logic       dly_rst_n,
    input  logic       sys_clk_lock,
    input  logic       idelay_rdy,
    input  logic       soft_rst_req,
    output logic       idelay_rst,
    output logic       user_rst,
    output logic       seq_done,
    output logic       seq_err,
    output logic [1:0] retry_cnt
);

    localparam int CNT_MAX = max_int(max_int(LOCK_CYCLES, IDLY_RST_CYCLES),
                                     max_int(USER_RST_CYCLES, TIMEOUT_CYCLES));
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int FAIL_W  = max_int(2, cnt_width(MAX_RETRIES + 1));

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLY_LAST = CNT_W'(IDLY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] USER_LAST = CNT_W'(USER_RST_CYCLES - 1);

    logic [2:0] async_in;
    logic [2:0] sync_out;
    logic       lock_s;
    logic       rdy_s;
    logic       soft_s;
    logic       soft_edge;

    rst_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [FAIL_W-1:0] fail_cnt_reg, fail_cnt_next;
    logic              soft_prev_reg;

    assign async_in = {soft_rst_req, idelay_rdy, sys_clk_lock};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            rst_seq_sync u_sync (
                .clk   (dly_clk),
                .rst_n (dly_rst_n),
                .d     (async_in[gi]),
                .q     (sync_out[gi])
            );
        end
    endgenerate

    assign lock_s    = sync_out[0];
    assign rdy_s     = sync_out[1];
    assign soft_s    = sync_out[2];
    assign soft_edge = soft_s & ~soft_prev_reg;

    always_ff @(posedge dly_clk or negedge dly_rst_n) begin
        if (!dly_rst_n) begin
            state_reg     <= ST_WAIT_LOCK;
            cnt_reg       <= '0;
            fail_cnt_reg  <= '0;
            soft_prev_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            fail_cnt_reg  <= fail_cnt_next;
            soft_prev_reg <= soft_s;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        fail_cnt_next = fail_cnt_reg;

        case (state_reg)
            ST_WAIT_LOCK: begin
                cnt_next = '0;
                if (lock_s) state_next = ST_LOCK_QUAL;
            end
            ST_LOCK_QUAL: begin
                if (cnt_reg == LOCK_LAST) begin
                    state_next = ST_IDLY_RST;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_IDLY_RST: begin
                if (cnt_reg == IDLY_LAST) begin
                    state_next = ST_IDLY_WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_IDLY_WAIT: begin
                if (rdy_s) begin
                    state_next = ST_USER_RST;
                    cnt_next   = '0;
                end
`ifdef RST_SEQ_TIMEOUT_EN
                else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cnt_next = '0;
                    if (fail_cnt_reg >= FAIL_W'(MAX_RETRIES)) begin
                        state_next = ST_ERROR;
                    end else begin
                        state_next    = ST_IDLY_RST;
                        fail_cnt_next = fail_cnt_reg + FAIL_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
`endif
            end
            ST_USER_RST: begin
                if (cnt_reg == USER_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (soft_edge) begin
                    state_next    = ST_IDLY_RST;
                    cnt_next      = '0;
                    fail_cnt_next = '0;
                end else if (!rdy_s) begin
                    state_next = ST_IDLY_RST;
                    cnt_next   = '0;
                    if (fail_cnt_reg != '1) fail_cnt_next = fail_cnt_reg + FAIL_W'(1);
                end
            end
            ST_ERROR: begin
                if (soft_edge) begin
                    state_next    = ST_IDLY_RST;
                    cnt_next      = '0;
                    fail_cnt_next = '0;
                end
            end
            default: begin
                state_next = ST_WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase

        // Losing lock overrides every other decision, including a soft request.
        if (!lock_s && state_reg != ST_WAIT_LOCK) begin
            state_next    = ST_WAIT_LOCK;
            cnt_next      = '0;
            fail_cnt_next = '0;
        end
    end

    always_comb begin
        idelay_rst = 1'b0;
        user_rst   = 1'b1;
        seq_done   = 1'b0;
        case (state_reg)
            ST_WAIT_LOCK, ST_LOCK_QUAL, ST_IDLY_RST: idelay_rst = 1'b1;
            ST_RUN: begin
                user_rst = 1'b0;
                seq_done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef RST_SEQ_TIMEOUT_EN
    assign seq_err = (state_reg == ST_ERROR);
`else
    assign seq_err = 1'b0;
`endif

    assign retry_cnt = (fail_cnt_reg > FAIL_W'(3)) ? 2'd3 : fail_cnt_reg[1:0];

endmodule

// File: tb/tb_roach_reset_sequencer.sv
// Scoreboard bench for roach_reset_sequencer: every output change is popped
// against a queue of hand-computed {cycle, outputs} entries. Follows RST_SEQ_TIMEOUT_EN.
module tb_roach_reset_sequencer;

    logic       dly_clk;
    logic       dly_rst_n;
    logic       sys_clk_lock;
    logic       idelay_rdy;
    logic       soft_rst_req;
    logic       idelay_rst;
    logic       user_rst;
    logic       seq_done;
    logic       seq_err;
    logic [1:0] retry_cnt;

    roach_reset_sequencer #(
        .LOCK_CYCLES     (8),
        .IDLY_RST_CYCLES (4),
        .USER_RST_CYCLES (6),
        .TIMEOUT_CYCLES  (20),
        .MAX_RETRIES     (3)
    ) dut (
        .dly_clk      (dly_clk),
        .dly_rst_n    (dly_rst_n),
        .sys_clk_lock (sys_clk_lock),
        .idelay_rdy   (idelay_rdy),
        .soft_rst_req (soft_rst_req),
        .idelay_rst   (idelay_rst),
        .user_rst     (user_rst),
        .seq_done     (seq_done),
        .seq_err      (seq_err),
        .retry_cnt    (retry_cnt)
    );

    // Output vector: {idelay_rst, user_rst, seq_done, seq_err, retry_cnt}
    typedef struct {
        int         cyc;
        logic [5:0] v;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [5:0] prev_v = 'x;

    initial dly_clk = 1'b0;
    always #5 dly_clk = ~dly_clk;
    always @(posedge dly_clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [5:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge dly_clk);
            #1;
        end
    endtask

    always @(negedge dly_clk) begin
        logic [5:0] v;
        exp_t       e;
        v = {idelay_rst, user_rst, seq_done, seq_err, retry_cnt};
        if (v !== prev_v) begin
            prev_v = v;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: got outputs=%b at cyc %0d, required no change", v, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.v !== v || e.cyc != cyc) begin
                    bad++;
                    $display("FAIL out_change: got outputs=%b at cyc %0d, required outputs=%b at cyc %0d",
                             v, cyc, e.v, e.cyc);
                end else begin
                    $display("chk cyc=%0d outputs=%b ok", cyc, v);
                end
            end
        end
    end

    initial begin
        int k, j, m, n, s, f, g;
        dly_rst_n    = 1'b0;
        sys_clk_lock = 1'b0;
        idelay_rdy   = 1'b0;
        soft_rst_req = 1'b0;
        push(1, 6'b110000);
        goto_cyc(3);
        dly_rst_n = 1'b1;

        // Normal bring-up: ready arrives 3 cycles after idelay_rst falls.
        goto_cyc(5);
        k = cyc;
        sys_clk_lock = 1'b1;
        push(k + 15, 6'b010000);
        push(k + 27, 6'b001000);
        goto_cyc(k + 18);
        idelay_rdy = 1'b1;
        goto_cyc(k + 30);

        // Ready drop in RUN: retry 1, 4-cycle idelay_rst pulse, recover.
        j = cyc;
        idelay_rdy = 1'b0;
        push(j + 3, 6'b110001);
        push(j + 7, 6'b010001);
        goto_cyc(j + 9);
        idelay_rdy = 1'b1;
        push(j + 18, 6'b001001);
        goto_cyc(j + 22);

        // Lock loss and soft request together: lock loss wins, retry cleared.
        m = cyc;
        sys_clk_lock = 1'b0;
        soft_rst_req = 1'b1;
        push(m + 3, 6'b110000);
        goto_cyc(m + 5);
        soft_rst_req = 1'b0;
        goto_cyc(m + 8);

        // One-cycle lock glitch at qualify count 5 restarts qualification.
        n = cyc;
        sys_clk_lock = 1'b1;
        push(n + 22, 6'b010000);
        push(n + 29, 6'b001000);
        goto_cyc(n + 6);
        sys_clk_lock = 1'b0;
        goto_cyc(n + 7);
        sys_clk_lock = 1'b1;
        goto_cyc(n + 32);

        // Soft request in RUN re-runs the IDELAY sequence; held level does not retrigger.
        s = cyc;
        soft_rst_req = 1'b1;
        push(s + 3, 6'b110000);
        push(s + 7, 6'b010000);
        push(s + 14, 6'b001000);
        goto_cyc(s + 16);
        soft_rst_req = 1'b0;
        goto_cyc(s + 20);

        // idelay_rdy stuck low after a soft request.
        f = cyc;
        soft_rst_req = 1'b1;
        idelay_rdy   = 1'b0;
        push(f + 3, 6'b110000);
        push(f + 7, 6'b010000);
        goto_cyc(f + 5);
        soft_rst_req = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
        push(f + 27, 6'b110001);
        push(f + 31, 6'b010001);
        push(f + 51, 6'b110010);
        push(f + 55, 6'b010010);
        push(f + 75, 6'b110011);
        push(f + 79, 6'b010011);
        push(f + 99, 6'b010111);
        goto_cyc(f + 105);
        f = cyc;
        soft_rst_req = 1'b1;
        push(f + 3, 6'b110000);
        push(f + 7, 6'b010000);
        goto_cyc(f + 8);
        idelay_rdy = 1'b1;
        push(f + 17, 6'b001000);
        goto_cyc(f + 10);
        soft_rst_req = 1'b0;
        goto_cyc(f + 20);
`else
        goto_cyc(f + 50);
        idelay_rdy = 1'b1;
        push(f + 59, 6'b001000);
        goto_cyc(f + 62);
`endif

        // Asynchronous reset during IDLY_WAIT, then a clean restart.
        g = cyc;
        soft_rst_req = 1'b1;
        idelay_rdy   = 1'b0;
        push(g + 3, 6'b110000);
        push(g + 7, 6'b010000);
        goto_cyc(g + 5);
        soft_rst_req = 1'b0;
        goto_cyc(g + 10);
        dly_rst_n = 1'b0;
        push(g + 10, 6'b110000);
        goto_cyc(g + 12);
        idelay_rdy = 1'b1;
        dly_rst_n  = 1'b1;
        push(g + 27, 6'b010000);
        push(g + 34, 6'b001000);
        goto_cyc(g + 45);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected: got %0d unmatched entries, required 0 (next at cyc %0d outputs=%b)",
                     exp_q.size(), exp_q[0].cyc, exp_q[0].v);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/roach_reset_sequencer.md
ROACH_RESET_SEQUENCER -- requirements
Module: roach_reset_sequencer

Interface
REQ-001 Parameter LOCK_CYCLES, default 1024: consecutive synced-lock cycles required before leaving lock-qualify.
REQ-002 Parameter IDLY_RST_CYCLES, default 16: idelay_rst pulse width in dly_clk cycles.
REQ-003 Parameter USER_RST_CYCLES, default 64: user_rst hold time after IDELAY ready.
REQ-004 Parameter TIMEOUT_CYCLES, default 4096: max wait for idelay_rdy per attempt.
REQ-005 Parameter MAX_RETRIES, default 3: failed attempts tolerated before error.
REQ-006 Port dly_clk, input, 1: free-running 200 MHz reference clock; sole clock of the block.
REQ-007 Port dly_rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port sys_clk_lock, input, 1: clock-manager lock, asynchronous to dly_clk.
REQ-009 Port idelay_rdy, input, 1: IDELAYCTRL ready, asynchronous.
REQ-010 Port soft_rst_req, input, 1: software re-sequence request level, asynchronous.
REQ-011 Port idelay_rst, output, 1: drives infrastructure idelay_rst, active-high.
REQ-012 Port user_rst, output, 1: application reset, active-high, dly_clk domain.
REQ-013 Port seq_done, output, 1: high only in RUN.
REQ-014 Port seq_err, output, 1: high only in ERROR.
REQ-015 Port retry_cnt, output, 2: failed attempts since last lock/soft request, saturating at 3.

Function
REQ-016 sys_clk_lock, idelay_rdy, soft_rst_req each SHALL pass a 2-flop synchronizer; all decisions use synced values (2-cycle input latency).
REQ-017 States SHALL be WAIT_LOCK, LOCK_QUAL, IDLY_RST, IDLY_WAIT, USER_RST, RUN, ERROR.
REQ-018 WAIT_LOCK: go to LOCK_QUAL when synced lock is 1; counter cleared.
REQ-019 LOCK_QUAL: count cycles with lock high; lock low returns to WAIT_LOCK; count reaching LOCK_CYCLES goes to IDLY_RST.
REQ-020 IDLY_RST: idelay_rst=1 for exactly IDLY_RST_CYCLES cycles, then IDLY_WAIT.
REQ-021 IDLY_WAIT: idelay_rst=0; synced idelay_rdy=1 goes to USER_RST.
REQ-022 USER_RST: user_rst held 1 for USER_RST_CYCLES cycles, then RUN; user_rst deasserts on the RUN-entry edge.
REQ-023 RUN: user_rst=0, seq_done=1; idelay_rdy dropping to 0 counts as a failure and re-enters IDLY_RST.
REQ-024 user_rst SHALL be 1 in every state except RUN.
REQ-025 Synced lock low in any state other than WAIT_LOCK SHALL force WAIT_LOCK next cycle and clear retry_cnt; this has priority over all other transitions.
REQ-026 Rising edge of synced soft_rst_req in RUN or ERROR SHALL go to IDLY_RST and clear retry_cnt; ignored in other states.
REQ-027 Lock loss and soft-request edge in the same cycle: lock loss wins.
REQ-028 All internal counters SHALL be wide enough for their parameter and never wrap.

Reset
REQ-029 On dly_rst_n low: state WAIT_LOCK, idelay_rst=1, user_rst=1, seq_done=0, seq_err=0, retry_cnt=0, counters and synchronizers 0.
REQ-030 Reset release SHALL be honoured at any point mid-sequence with identical resulting state.

Configuration
REQ-031 Macro RST_SEQ_TIMEOUT_EN defined: IDLY_WAIT exceeding TIMEOUT_CYCLES increments retry_cnt and returns to IDLY_RST; when the attempt count would exceed MAX_RETRIES go to ERROR (idelay_rst=0, user_rst=1, seq_err=1).
REQ-032 Macro undefined: IDLY_WAIT waits indefinitely, ERROR unreachable, seq_err tied 0, retry_cnt counts only RUN-state ready drops.

Structure
REQ-033 Shared package roach_rst_pkg SHALL hold the state enumeration and default parameter constants.
REQ-034 One sub-module, rst_seq_sync (2-flop synchronizer, async active-low reset), instantiated per asynchronous input.

Verification (LOCK_CYCLES=8, IDLY_RST_CYCLES=4, USER_RST_CYCLES=6, TIMEOUT_CYCLES=20, MAX_RETRIES=3)
REQ-035 Lock rises, idelay_rdy rises 3 cycles after idelay_rst falls -> idelay_rst high exactly 4 cycles, user_rst falls 6 cycles after synced ready, seq_done=1.
REQ-036 Lock drops for 1 cycle at LOCK_QUAL count 5 -> return to WAIT_LOCK, full 8-cycle qualification repeated.
REQ-037 Timeout enabled, idelay_rdy stuck 0 -> retry_cnt 1,2,3, then ERROR with seq_err=1, user_rst=1; soft_rst_req edge restarts at IDLY_RST with retry_cnt=0.
REQ-038 In RUN, lock drop and soft_rst_req edge same cycle -> WAIT_LOCK, user_rst=1, seq_done=0.
REQ-039 dly_rst_n asserted during IDLY_WAIT -> all outputs at REQ-029 values asynchronously; sequence restarts on release.
